// File: rtl/mac_stream_ctrl.sv
// Streams operand chunks from two SRAM read ports into core_mac and folds the
// returned partial sums into a signed saturating accumulator per command.
module mac_stream_ctrl #(
  parameter int MAC_NUM       = 8,
  parameter int IDATA_BIT     = 8,
  parameter int MAC_ODATA_BIT = 19,
  parameter int ACC_BIT       = 32,
  parameter int ADDR_BIT      = 10,
  parameter int LEN_BIT       = 10
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_BIT-1:0]          cmd_addr_a,
  input  logic [ADDR_BIT-1:0]          cmd_addr_b,
  input  logic [LEN_BIT-1:0]           cmd_len,
  output logic                         mem_a_ren,
  output logic                         mem_b_ren,
  output logic [ADDR_BIT-1:0]          mem_a_addr,
  output logic [ADDR_BIT-1:0]          mem_b_addr,
  input  logic [IDATA_BIT*MAC_NUM-1:0] mem_a_rdata,
  input  logic [IDATA_BIT*MAC_NUM-1:0] mem_b_rdata,
  output logic [IDATA_BIT*MAC_NUM-1:0] mac_idataA,
  output logic [IDATA_BIT*MAC_NUM-1:0] mac_idataB,
  output logic                         mac_idata_valid,
  input  logic [MAC_ODATA_BIT-1:0]     mac_odata,
  input  logic                         mac_odata_valid,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [ACC_BIT-1:0]           res_data,
  output logic                         res_sat
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  localparam logic [ACC_BIT-1:0] ACC_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
  localparam logic [ACC_BIT-1:0] ACC_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};

  state_e               state_q, state_d;
  logic [ADDR_BIT-1:0]  addr_a_q, addr_a_d;
  logic [ADDR_BIT-1:0]  addr_b_q, addr_b_d;
  logic [LEN_BIT-1:0]   len_q, len_d;
  logic [LEN_BIT-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LEN_BIT-1:0]   ret_cnt_q, ret_cnt_d;
  logic [ACC_BIT-1:0]   acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic                 ren_q, ren_d;
  logic                 idata_valid_q, idata_valid_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 res_valid_q, res_valid_d;

  // One extra bit of headroom: a disagreement between the top two bits of the
  // widened sum means the true result left the ACC_BIT signed range.
  logic [ACC_BIT:0]     sum;
  logic                 sum_ovf;
  logic [ACC_BIT-1:0]   sum_clamped;
  logic                 take_ret;

  always_comb begin
    sum         = {acc_q[ACC_BIT-1], acc_q}
                + {{(ACC_BIT+1-MAC_ODATA_BIT){mac_odata[MAC_ODATA_BIT-1]}}, mac_odata};
    sum_ovf     = sum[ACC_BIT] != sum[ACC_BIT-1];
    sum_clamped = sum_ovf ? (sum[ACC_BIT] ? ACC_MIN : ACC_MAX) : sum[ACC_BIT-1:0];
    take_ret    = mac_odata_valid && (state_q == S_ISSUE || state_q == S_DRAIN);
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    addr_a_d      = addr_a_q;
    addr_b_d      = addr_b_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    ret_cnt_d     = ret_cnt_q;
    acc_d         = acc_q;
    sat_d         = sat_q;
    ren_d         = ren_q;
    idata_valid_d = ren_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_a_d    = cmd_addr_a;
          addr_b_d    = cmd_addr_b;
          len_d       = cmd_len;
          acc_d       = '0;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          sat_d       = 1'b0;
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            ren_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + LEN_BIT'(1);
        if (issue_cnt_q == len_q - LEN_BIT'(1)) begin
          state_d = S_DRAIN;
          ren_d   = 1'b0;
        end else begin
          addr_a_d = addr_a_q + ADDR_BIT'(1);
          addr_b_d = addr_b_q + ADDR_BIT'(1);
        end
      end
      S_DRAIN: ;
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The final return and the DONE transition share an edge, so res_data is
    // already the finished sum on the first res_valid cycle.
    if (take_ret) begin
      acc_d     = sum_clamped;
      sat_d     = sat_q | sum_ovf;
      ret_cnt_d = ret_cnt_q + LEN_BIT'(1);
      if (ret_cnt_q == len_q - LEN_BIT'(1)) begin
        state_d = S_DONE;
        ren_d   = 1'b0;
      end
    end

    cmd_ready_d = (state_d == S_IDLE);
    res_valid_d = (state_d == S_DONE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      addr_a_q      <= '0;
      addr_b_q      <= '0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      ret_cnt_q     <= '0;
      acc_q         <= '0;
      sat_q         <= 1'b0;
      ren_q         <= 1'b0;
      idata_valid_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_a_q      <= addr_a_d;
      addr_b_q      <= addr_b_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      ret_cnt_q     <= ret_cnt_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      ren_q         <= ren_d;
      idata_valid_q <= idata_valid_d;
      cmd_ready_q   <= cmd_ready_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign mem_a_ren       = ren_q;
  assign mem_b_ren       = ren_q;
  assign mem_a_addr      = addr_a_q;
  assign mem_b_addr      = addr_b_q;
  assign mac_idataA      = mem_a_rdata;
  assign mac_idataB      = mem_b_rdata;
  assign mac_idata_valid = idata_valid_q;
  assign res_valid       = res_valid_q;
  assign res_data        = acc_q;
  assign res_sat         = sat_q;

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Bench for mac_stream_ctrl: SRAM and 3-cycle core_mac models around the DUT,
// a per-cycle reference model, and directed commands with literal results.
module tb_mac_stream_ctrl;

  localparam int MN    = 8;
  localparam int IB    = 8;
  localparam int OB    = 19;
  localparam int AB    = 20;
  localparam int ADB   = 10;
  localparam int LB    = 10;
  localparam int LAT   = 3;
  localparam int CW    = IB * MN;
  localparam int DEPTH = 1 << ADB;
  localparam longint ACC_MAXV = (64'sd1 <<< (AB - 1)) - 1;
  localparam longint ACC_MINV = -(64'sd1 <<< (AB - 1));

  logic           clk, rstn;
  logic           cmd_valid, cmd_ready;
  logic [ADB-1:0] cmd_addr_a, cmd_addr_b;
  logic [LB-1:0]  cmd_len;
  logic           mem_a_ren, mem_b_ren;
  logic [ADB-1:0] mem_a_addr, mem_b_addr;
  logic [CW-1:0]  mem_a_rdata, mem_b_rdata;
  logic [CW-1:0]  mac_idataA, mac_idataB;
  logic           mac_idata_valid;
  logic [OB-1:0]  mac_odata;
  logic           mac_odata_valid;
  logic           res_valid, res_ready;
  logic [AB-1:0]  res_data;
  logic           res_sat;

  logic [CW-1:0]  mem_a [DEPTH];
  logic [CW-1:0]  mem_b [DEPTH];
  logic [LAT-1:0] pv;
  logic [OB-1:0]  pd [LAT];
  logic           spur_v;
  logic [OB-1:0]  spur_d;

  int n_cmp = 0;
  int n_bad = 0;
  int addr_log_a[$];
  int addr_log_b[$];

  mac_stream_ctrl #(
    .MAC_NUM(MN), .IDATA_BIT(IB), .MAC_ODATA_BIT(OB),
    .ACC_BIT(AB), .ADDR_BIT(ADB), .LEN_BIT(LB)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_len(cmd_len),
    .mem_a_ren(mem_a_ren), .mem_b_ren(mem_b_ren),
    .mem_a_addr(mem_a_addr), .mem_b_addr(mem_b_addr),
    .mem_a_rdata(mem_a_rdata), .mem_b_rdata(mem_b_rdata),
    .mac_idataA(mac_idataA), .mac_idataB(mac_idataB),
    .mac_idata_valid(mac_idata_valid),
    .mac_odata(mac_odata), .mac_odata_valid(mac_odata_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_sat(res_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint chunk_dot(input logic [CW-1:0] a, input logic [CW-1:0] b);
    longint s = 0;
    for (int l = 0; l < MN; l++)
      s += longint'($signed(a[l*IB +: IB])) * longint'($signed(b[l*IB +: IB]));
    return s;
  endfunction

  // SRAMs with one cycle read latency
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_a_rdata <= '0;
      mem_b_rdata <= '0;
    end else begin
      if (mem_a_ren) mem_a_rdata <= mem_a[mem_a_addr];
      if (mem_b_ren) mem_b_rdata <= mem_b[mem_b_addr];
    end
  end

  // core_mac stand-in: dot product delivered LAT cycles after idata_valid
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mac_idata_valid};
      pd[0] <= OB'(chunk_dot(mac_idataA, mac_idataB));
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end
  end

  assign mac_odata_valid = pv[LAT-1] | spur_v;
  assign mac_odata       = spur_v ? spur_d : pd[LAT-1];

  // Reference model: expected result computed from memory contents at accept
  // time, and the cycle schedule expressed as cycle numbers since acceptance.
  bit     m_idle = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_sat = 1'b0;
  int     m_cyc = 0, m_len = 0, m_a = 0, m_b = 0;
  longint m_res = 0;

  always @(negedge clk) begin
    bit exp_ren, exp_idv;
    if (!rstn) begin
      m_idle = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_cyc = 0;
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_ren", {mem_a_ren, mem_b_ren}, 0);
      check("rst_addr", {mem_a_addr, mem_b_addr}, 0);
      check("rst_idata_valid", mac_idata_valid, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_sat", res_sat, 0);
    end else begin
      exp_ren = m_busy && m_cyc >= 1 && m_cyc <= m_len;
      exp_idv = m_busy && m_cyc >= 2 && m_cyc <= m_len + 1;
      check("cyc_cmd_ready", cmd_ready, m_idle);
      check("cyc_ren_a", mem_a_ren, exp_ren);
      check("cyc_ren_b", mem_b_ren, exp_ren);
      if (exp_ren) begin
        check("cyc_addr_a", mem_a_addr, (m_a + m_cyc - 1) % DEPTH);
        check("cyc_addr_b", mem_b_addr, (m_b + m_cyc - 1) % DEPTH);
      end
      check("cyc_idata_valid", mac_idata_valid, exp_idv);
      if (exp_idv) begin
        check("cyc_idataA", mac_idataA, mem_a[(m_a + m_cyc - 2) % DEPTH]);
        check("cyc_idataB", mac_idataB, mem_b[(m_b + m_cyc - 2) % DEPTH]);
      end
      check("cyc_res_valid", res_valid, m_done);
      if (m_done) begin
        check("cyc_res_data", $signed(res_data), m_res);
        check("cyc_res_sat", res_sat, m_sat);
      end
      // advance the model across the coming edge
      if (m_idle && cmd_valid) begin
        m_idle = 1'b0;
        m_a = int'(cmd_addr_a); m_b = int'(cmd_addr_b); m_len = int'(cmd_len);
        m_res = 0; m_sat = 1'b0;
        for (int k = 0; k < m_len; k++) begin
          m_res += chunk_dot(mem_a[(m_a + k) % DEPTH], mem_b[(m_b + k) % DEPTH]);
          if (m_res > ACC_MAXV) begin m_res = ACC_MAXV; m_sat = 1'b1; end
          else if (m_res < ACC_MINV) begin m_res = ACC_MINV; m_sat = 1'b1; end
        end
        m_cyc = 1;
        if (m_len == 0) m_done = 1'b1;
        else m_busy = 1'b1;
      end else if (m_busy) begin
        m_cyc++;
        if (m_cyc == m_len + 2 + LAT) begin m_busy = 1'b0; m_done = 1'b1; end
      end else if (m_done && res_ready) begin
        m_done = 1'b0; m_idle = 1'b1;
      end
    end
  end

  task automatic fill(input int a_addr, input int a_val, input int b_addr, input int b_val);
    mem_a[a_addr] = {MN{IB'(a_val)}};
    mem_b[b_addr] = {MN{IB'(b_val)}};
  endtask

  // Issues one command from IDLE and checks it against hand-computed values.
  task automatic run_cmd(input string tag, input int a, input int b, input int len,
                         input longint exp_data, input int exp_sat, input int exp_lat,
                         input int hold);
    int n, rens;
    addr_log_a.delete();
    addr_log_b.delete();
    cmd_valid = 1'b1; cmd_addr_a = ADB'(a); cmd_addr_b = ADB'(b); cmd_len = LB'(len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 1; rens = 0;
    while (!res_valid && n < 400) begin
      if (mem_a_ren) begin
        rens++;
        addr_log_a.push_back(int'(mem_a_addr));
        addr_log_b.push_back(int'(mem_b_addr));
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_ren_count"}, rens, len);
    check({tag, "_res_data"}, $signed(res_data), exp_data);
    check({tag, "_res_sat"}, res_sat, exp_sat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, res_valid, 1);
      check({tag, "_hold_data"}, $signed(res_data), exp_data);
      check({tag, "_hold_cmd_ready"}, cmd_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, res_valid, 0);
    check({tag, "_cmd_ready_back"}, cmd_ready, 1);
  endtask

  initial begin
    int seen;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_addr_a = '0; cmd_addr_b = '0; cmd_len = '0;
    res_ready = 1'b0; spur_v = 1'b0; spur_d = '0;
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    fill(10, 3, 20, -2);
    for (int k = 0; k < 4; k++) fill(100 + k, k + 1, 200 + k, 1);
    fill(1022, 1, 5, 2); fill(1023, 1, 6, 2); fill(0, 1, 7, 2);
    for (int k = 0; k < 32; k++) fill(300 + k, -128, 400 + k, -128);
    fill(500, 1, 500, 1);
    for (int k = 0; k < 5; k++) fill(600 + k, -128, 600 + k, 127);

    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_res_data", res_data, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_cmd("basic", 10, 20, 1, -48, 0, 6, 0);
    run_cmd("multi", 100, 200, 4, 80, 0, 9, 0);
    for (int i = 0; i < 4; i++) check("multi_addr_a", addr_log_a[i], 100 + i);
    run_cmd("wrap", 1022, 5, 3, 48, 0, 8, 0);
    check("wrap_addr_a0", addr_log_a[0], 1022);
    check("wrap_addr_a1", addr_log_a[1], 1023);
    check("wrap_addr_a2", addr_log_a[2], 0);
    check("wrap_addr_b2", addr_log_b[2], 7);
    run_cmd("sat_pos", 300, 400, 32, 524287, 1, 37, 0);
    run_cmd("after_sat", 500, 500, 1, 8, 0, 6, 0);
    run_cmd("sat_neg", 600, 600, 5, -524288, 1, 10, 0);
    run_cmd("zero_len", 0, 0, 0, 0, 0, 1, 5);

    // reset while the len=8 command is still issuing
    cmd_valid = 1'b1; cmd_addr_a = 10'd300; cmd_addr_b = 10'd400; cmd_len = 10'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_in_issue", mem_a_ren, 1);
    rstn = 1'b0;
    #1;
    check("midrst_ren", mem_a_ren, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_res_data", res_data, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    check("midrst_no_result", seen, 0);

    // spurious partial sum while idle must not reach the next result
    spur_d = OB'(12345); spur_v = 1'b1;
    @(posedge clk); #1;
    spur_v = 1'b0;
    run_cmd("post_spur", 10, 20, 1, -48, 0, 6, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
